// File: rtl/mips_md_pkg.sv
// Shared encodings and arithmetic helpers for the MIPS multiply/divide unit.
// Pure definitions: no latency, no flow control.
package mips_md_pkg;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   localparam int MD_ITER = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } md_state_t;

   // 33-bit result so that the magnitude of 0x80000000 is representable.
   function automatic logic [32:0] abs33(input logic [31:0] v, input logic is_signed);
      logic [32:0] ext;
      ext = {is_signed & v[31], v};
      return ext[32] ? (33'd0 - ext) : ext;
   endfunction

   function automatic logic [63:0] neg64(input logic [63:0] v);
      return ~v + 64'd1;
   endfunction

endpackage

// File: rtl/mips_mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; fixed 33-cycle latency from start to result.
// No backpressure: requests are dropped while busy, so control must stall on sig_md_busy.
module mips_mult_div
   import mips_md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [1:0]       sig_md_op,
   input  logic             sig_md_start,
   input  logic             sig_mthi,
   input  logic             sig_mtlo,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             sig_md_busy,
   output logic             sig_md_done
);

   md_state_t   r_state;
   logic [1:0]  r_op;
   logic        r_sign_a;
   logic        r_sign_b;
   logic [32:0] r_mag_a;
   logic [32:0] r_mag_b;
   logic [31:0] r_a_raw;
   logic [63:0] r_acc;
   logic [32:0] r_rem;
   logic [4:0]  r_cnt;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_busy;
   logic        r_done;

   logic        w_start_signed;
   logic        w_start_div;
   logic [32:0] w_abs_a;
   logic [32:0] w_abs_b;
   logic        w_is_div;
   logic        w_is_signed;
   logic        w_neg_res;
   logic [32:0] w_sum;
   logic [33:0] w_trial;
   logic        w_ge;
   logic [32:0] w_diff;
   logic [63:0] w_prod;
   logic [31:0] w_quo;
   logic [31:0] w_rmd;

   assign w_start_signed = (sig_md_op == MD_MULT) || (sig_md_op == MD_DIV);
   assign w_start_div    = (sig_md_op == MD_DIV)  || (sig_md_op == MD_DIVU);
   assign w_abs_a        = abs33(operand_a, w_start_signed);
   assign w_abs_b        = abs33(operand_b, w_start_signed);

   assign w_is_div    = (r_op == MD_DIV)  || (r_op == MD_DIVU);
   assign w_is_signed = (r_op == MD_MULT) || (r_op == MD_DIV);
   assign w_neg_res   = w_is_signed && (r_sign_a ^ r_sign_b);

   // Multiply: upper half accumulates, lower half shifts the multiplier out LSB first.
   assign w_sum = {1'b0, r_acc[63:32]} + r_mag_a;

   // Divide: r_acc[31:0] shifts the dividend out MSB first and the quotient in.
   assign w_trial = {r_rem, r_acc[31]};
   assign w_ge    = w_trial >= {1'b0, r_mag_b};
   assign w_diff  = w_trial[32:0] - r_mag_b;

   assign w_prod = w_neg_res ? neg64(r_acc) : r_acc;
   assign w_quo  = w_neg_res ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
   assign w_rmd  = (w_is_signed && r_sign_a) ? (32'd0 - r_rem[31:0]) : r_rem[31:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_op     <= MD_MULT;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_mag_a  <= '0;
         r_mag_b  <= '0;
         r_a_raw  <= '0;
         r_acc    <= '0;
         r_rem    <= '0;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (sig_md_start) begin
                  r_op     <= sig_md_op;
                  r_sign_a <= w_start_signed & operand_a[31];
                  r_sign_b <= w_start_signed & operand_b[31];
                  r_mag_a  <= w_abs_a;
                  r_mag_b  <= w_abs_b;
                  r_a_raw  <= operand_a;
                  r_acc    <= {32'd0, (w_start_div ? w_abs_a[31:0] : w_abs_b[31:0])};
                  r_rem    <= '0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_RUN;
               end else begin
                  if (sig_mthi) r_hi <= operand_a;
                  if (sig_mtlo) r_lo <= operand_a;
               end
            end
            ST_RUN: begin
               if (w_is_div) begin
                  r_acc[31:0] <= {r_acc[30:0], w_ge};
                  r_rem       <= w_ge ? w_diff : w_trial[32:0];
               end else if (r_acc[0]) begin
                  r_acc <= {w_sum, r_acc[31:1]};
               end else begin
                  r_acc <= {1'b0, r_acc[63:1]};
               end
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'(MD_ITER - 1)) r_state <= ST_FIX;
            end
            ST_FIX: begin
               if (!w_is_div) begin
                  r_hi <= w_prod[63:32];
                  r_lo <= w_prod[31:0];
               end else if (r_mag_b == 33'd0) begin
                  r_hi <= r_a_raw;
                  r_lo <= 32'hFFFF_FFFF;
               end else begin
                  r_hi <= w_rmd;
                  r_lo <= w_quo;
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign hi_out      = r_hi;
   assign lo_out      = r_lo;
   assign sig_md_busy = r_busy;
   assign sig_md_done = r_done;

endmodule
